// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset core.
// Define CU_BUS_TIMEOUT_EN to enable the bus-response watchdog (TRAP with bus_error).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for RUN
// FETCH  | instruction read: start pulse, then wait for rdata_valid
// DECODE | classify held instruction, illegal -> TRAP
// EXEC   | drive ALU operand selects, latch alu_zero for branches
// MEM    | data access for LW/SW: start pulse, then wait for response
// WB     | register write-back and PC update
// TRAP   | sticky halt, only rst_n leaves it

module multicycle_ctrl #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RUN,
    input  logic [31:0]     instruction,
    input  logic            alu_zero,
    input  logic            BUS_rdata_valid,
    input  logic            BUS_write_done,
    output logic [2:0]      reg_mux_CS,
    output logic [4:0]      reg_rd,
    output logic [4:0]      reg_rs1,
    output logic [4:0]      reg_rs2,
    output logic            reg_wen,
    output logic [1:0]      PC_CS,
    output logic            PC_EN,
    output logic [1:0]      ALU_mode,
    output logic [1:0]      ALU_CS1,
    output logic [1:0]      ALU_CS2,
    output logic            BUS_ADDR_CS,
    output logic            BUS_mode,
    output logic            BUS_start_transaction,
    output logic [XLEN-1:0] IM,
    output logic [2:0]      cur_state,
    output logic            trap,
    output logic            bus_error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE, OP_ADD, OP_SUB, OP_ADDI, OP_LUI,
        OP_LW, OP_SW, OP_JAL, OP_BEQ, OP_BNE
    } op_t;

    if (XLEN < 32 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("multicycle_ctrl: XLEN must be >= 32 and TIMEOUT_CYCLES >= 1");
    end

    state_t       state, state_n;
    logic [31:0]  ir;
    logic         ir_load;
    logic         zero_q;
    logic         first_q;
    op_t          op;
    logic signed [31:0] imm32;
    logic signed [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic         alu_active;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    assign i_imm = {{20{ir[31]}}, ir[31:20]};
    assign s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign u_imm = {ir[31:12], 12'b0};
    assign j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    always_comb begin
        op    = OP_NONE;
        imm32 = '0;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000)      op = OP_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) op = OP_SUB;
            end
            7'b0010011: begin
                if (funct3 == 3'b000) begin
                    op    = OP_ADDI;
                    imm32 = i_imm;
                end
            end
            7'b0110111: begin
                op    = OP_LUI;
                imm32 = u_imm;
            end
            7'b0000011: begin
                if (funct3 == 3'b010) begin
                    op    = OP_LW;
                    imm32 = i_imm;
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b010) begin
                    op    = OP_SW;
                    imm32 = s_imm;
                end
            end
            7'b1101111: begin
                op    = OP_JAL;
                imm32 = j_imm;
            end
            7'b1100011: begin
                if (funct3 == 3'b000) begin
                    op    = OP_BEQ;
                    imm32 = b_imm;
                end else if (funct3 == 3'b001) begin
                    op    = OP_BNE;
                    imm32 = b_imm;
                end
            end
            default: ;
        endcase
    end

    // Signed size cast: wider datapaths get the immediate sign-extended.
    assign IM        = XLEN'(imm32);
    assign reg_rd    = ir[11:7];
    assign reg_rs1   = ir[19:15];
    assign reg_rs2   = ir[24:20];
    assign cur_state = state;
    assign trap      = (state == S_TRAP);

`ifdef CU_BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] to_cnt;
    logic             to_tc;
    logic             timeout_hit;
    logic             bus_error_q;

    // Loaded at the start pulse; reaches zero on the last cycle a response may arrive.
    assign to_tc = (to_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (BUS_start_transaction) begin
            to_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_error_q <= 1'b0;
        end else if (timeout_hit) begin
            bus_error_q <= 1'b1;
        end
    end

    assign bus_error = bus_error_q;
`else
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ir      <= '0;
            zero_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state   <= state_n;
            first_q <= (state_n != state);
            if (ir_load) begin
                ir <= instruction;
            end
            if (state == S_EXEC && (op == OP_BEQ || op == OP_BNE)) begin
                zero_q <= alu_zero;
            end
        end
    end

    // A response in the start-pulse cycle belongs to no transaction and is ignored.
    always_comb begin
        state_n = state;
        ir_load = 1'b0;
`ifdef CU_BUS_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (RUN) state_n = S_FETCH;
            end
            S_FETCH: begin
                if (!first_q && BUS_rdata_valid) begin
                    ir_load = 1'b1;
                    state_n = S_DECODE;
                end
`ifdef CU_BUS_TIMEOUT_EN
                else if (!first_q && to_tc) begin
                    timeout_hit = 1'b1;
                    state_n     = S_TRAP;
                end
`endif
            end
            S_DECODE: begin
                state_n = (op == OP_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                state_n = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (!first_q && ((op == OP_SW) ? BUS_write_done : BUS_rdata_valid)) begin
                    state_n = S_WB;
                end
`ifdef CU_BUS_TIMEOUT_EN
                else if (!first_q && to_tc) begin
                    timeout_hit = 1'b1;
                    state_n     = S_TRAP;
                end
`endif
            end
            S_WB: begin
                state_n = RUN ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                state_n = S_TRAP;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // ALU selects stay valid from EXEC through WB so the address and result hold steady.
    assign alu_active = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    always_comb begin
        reg_mux_CS            = 3'd0;
        reg_wen               = 1'b0;
        PC_CS                 = 2'd0;
        PC_EN                 = 1'b0;
        ALU_mode              = 2'd0;
        ALU_CS1               = 2'd0;
        ALU_CS2               = 2'd0;
        BUS_ADDR_CS           = 1'b0;
        BUS_mode              = 1'b0;
        BUS_start_transaction = 1'b0;

        if (alu_active) begin
            case (op)
                OP_SUB, OP_BEQ, OP_BNE:   ALU_mode = 2'd1;
                OP_ADDI, OP_LW, OP_SW:    ALU_CS2  = 2'd1;
                default: ;
            endcase
        end

        case (state)
            S_FETCH: begin
                BUS_start_transaction = first_q;
            end
            S_MEM: begin
                BUS_start_transaction = first_q;
                BUS_ADDR_CS           = 1'b1;
                BUS_mode              = (op == OP_SW);
            end
            S_WB: begin
                PC_EN = 1'b1;
                case (op)
                    OP_ADD, OP_SUB, OP_ADDI: begin
                        reg_wen    = 1'b1;
                        reg_mux_CS = 3'd0;
                    end
                    OP_LUI: begin
                        reg_wen    = 1'b1;
                        reg_mux_CS = 3'd2;
                    end
                    OP_LW: begin
                        reg_wen    = 1'b1;
                        reg_mux_CS = 3'd1;
                    end
                    OP_JAL: begin
                        reg_wen    = 1'b1;
                        reg_mux_CS = 3'd3;
                        PC_CS      = 2'd1;
                    end
                    OP_BEQ:  PC_CS = {1'b0, zero_q};
                    OP_BNE:  PC_CS = {1'b0, ~zero_q};
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table of single instructions
// plus hand sequences for start-cycle responses, trap, async reset and timeout.

module tb_multicycle_ctrl;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    logic            clk;
    logic            rst_n;
    logic            RUN;
    logic [31:0]     instruction;
    logic            alu_zero;
    logic            BUS_rdata_valid;
    logic            BUS_write_done;
    logic [2:0]      reg_mux_CS;
    logic [4:0]      reg_rd, reg_rs1, reg_rs2;
    logic            reg_wen;
    logic [1:0]      PC_CS;
    logic            PC_EN;
    logic [1:0]      ALU_mode, ALU_CS1, ALU_CS2;
    logic            BUS_ADDR_CS, BUS_mode, BUS_start_transaction;
    logic [XLEN-1:0] IM;
    logic [2:0]      cur_state;
    logic            trap, bus_error;

    multicycle_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .RUN                   (RUN),
        .instruction           (instruction),
        .alu_zero              (alu_zero),
        .BUS_rdata_valid       (BUS_rdata_valid),
        .BUS_write_done        (BUS_write_done),
        .reg_mux_CS            (reg_mux_CS),
        .reg_rd                (reg_rd),
        .reg_rs1               (reg_rs1),
        .reg_rs2               (reg_rs2),
        .reg_wen               (reg_wen),
        .PC_CS                 (PC_CS),
        .PC_EN                 (PC_EN),
        .ALU_mode              (ALU_mode),
        .ALU_CS1               (ALU_CS1),
        .ALU_CS2               (ALU_CS2),
        .BUS_ADDR_CS           (BUS_ADDR_CS),
        .BUS_mode              (BUS_mode),
        .BUS_start_transaction (BUS_start_transaction),
        .IM                    (IM),
        .cur_state             (cur_state),
        .trap                  (trap),
        .bus_error             (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        int          fw;
        int          mw;
        logic        z;
        int          cycles;
        int          starts;
        logic [31:0] im;
        logic [1:0]  mode;
        logic [1:0]  cs2;
        logic        wen;
        logic [2:0]  mux;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  pccs;
    } vec_t;

    typedef struct packed {
        logic        done;
        logic        trapped;
        int          cycles;
        int          starts;
        int          wen_cnt;
        int          pcen_cnt;
        logic [31:0] im;
        logic [1:0]  mode;
        logic [1:0]  cs1;
        logic [1:0]  cs2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wen;
        logic [2:0]  mux;
        logic [4:0]  rd;
        logic [1:0]  pccs;
        logic        pcen;
    } obs_t;

    int n_chk;
    int n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".state"}, 64'(cur_state), 64'd0);
        chk({name, ".ctrl"}, 64'({reg_mux_CS, reg_wen, PC_CS, PC_EN, ALU_mode, ALU_CS1, ALU_CS2,
                                  BUS_ADDR_CS, BUS_mode, BUS_start_transaction, trap}), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        RUN = 1'b0;
        instruction = '0;
        alu_zero = 1'b0;
        BUS_rdata_valid = 1'b0;
        BUS_write_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one instruction from IDLE; RUN is dropped once FETCH begins so the
    // controller must finish the instruction and return to IDLE on its own.
    task automatic exec_instr(input logic [31:0] ins, input int fw, input int mw,
                              input logic z, output obs_t o);
        int   cnt;
        logic pend;
        logic wr;
        o = '0;
        cnt = 0;
        pend = 1'b0;
        wr = 1'b0;
        instruction = ins;
        RUN = 1'b1;
        alu_zero = ~z;
        for (int i = 0; i < 80 && !o.done; i++) begin
            @(negedge clk);
            BUS_rdata_valid = 1'b0;
            BUS_write_done = 1'b0;
            alu_zero = (cur_state == ST_EXEC) ? z : ~z;
            if (cur_state != ST_IDLE) begin
                o.cycles++;
                RUN = 1'b0;
            end
            if (reg_wen) o.wen_cnt++;
            if (PC_EN) o.pcen_cnt++;
            if (BUS_start_transaction) begin
                o.starts++;
                pend = 1'b1;
                wr = BUS_mode;
                cnt = ((cur_state == ST_MEM) ? mw : fw) + 1;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 1'b0;
                    if (wr) BUS_write_done = 1'b1;
                    else    BUS_rdata_valid = 1'b1;
                end
            end
            case (cur_state)
                ST_DECODE: o.im = IM;
                ST_EXEC: begin
                    o.mode = ALU_mode;
                    o.cs1  = ALU_CS1;
                    o.cs2  = ALU_CS2;
                    o.rs1  = reg_rs1;
                    o.rs2  = reg_rs2;
                end
                ST_WB: begin
                    o.wen  = reg_wen;
                    o.mux  = reg_mux_CS;
                    o.rd   = reg_rd;
                    o.pccs = PC_CS;
                    o.pcen = PC_EN;
                    o.done = 1'b1;
                end
                ST_TRAP: begin
                    o.trapped = 1'b1;
                    o.done = 1'b1;
                end
                default: ;
            endcase
        end
        @(negedge clk);
        BUS_rdata_valid = 1'b0;
        BUS_write_done = 1'b0;
        RUN = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int   cnt_start;
        int   cnt_en;
        n_chk = 0;
        n_fail = 0;

        //            ins           fw mw z  cyc st im            mode cs2  wen mux  rd     rs1    rs2    pccs
        vecs[0]  = '{32'h00500093, 0, 0, 1'b0, 5, 1, 32'h00000005, 2'd0, 2'd1, 1'b1, 3'd0, 5'd1,  5'd0, 5'd5,  2'd0};
        vecs[1]  = '{32'h002081B3, 0, 0, 1'b0, 5, 1, 32'h00000000, 2'd0, 2'd0, 1'b1, 3'd0, 5'd3,  5'd1, 5'd2,  2'd0};
        vecs[2]  = '{32'h0080A283, 0, 2, 1'b0, 9, 2, 32'h00000008, 2'd0, 2'd1, 1'b1, 3'd1, 5'd5,  5'd1, 5'd8,  2'd0};
        vecs[3]  = '{32'h00208463, 0, 0, 1'b1, 5, 1, 32'h00000008, 2'd1, 2'd0, 1'b0, 3'd0, 5'd8,  5'd1, 5'd2,  2'd1};
        vecs[4]  = '{32'h00208463, 0, 0, 1'b0, 5, 1, 32'h00000008, 2'd1, 2'd0, 1'b0, 3'd0, 5'd8,  5'd1, 5'd2,  2'd0};
        vecs[5]  = '{32'h00209463, 0, 0, 1'b0, 5, 1, 32'h00000008, 2'd1, 2'd0, 1'b0, 3'd0, 5'd8,  5'd1, 5'd2,  2'd1};
        vecs[6]  = '{32'h00209463, 0, 0, 1'b1, 5, 1, 32'h00000008, 2'd1, 2'd0, 1'b0, 3'd0, 5'd8,  5'd1, 5'd2,  2'd0};
        vecs[7]  = '{32'h010000EF, 0, 0, 1'b0, 5, 1, 32'h00000010, 2'd0, 2'd0, 1'b1, 3'd3, 5'd1,  5'd0, 5'd16, 2'd1};
        vecs[8]  = '{32'h0020A623, 1, 0, 1'b0, 8, 2, 32'h0000000C, 2'd0, 2'd1, 1'b0, 3'd0, 5'd12, 5'd1, 5'd2,  2'd0};
        vecs[9]  = '{32'h123453B7, 0, 0, 1'b0, 5, 1, 32'h12345000, 2'd0, 2'd0, 1'b1, 3'd2, 5'd7,  5'd8, 5'd3,  2'd0};
        vecs[10] = '{32'h40208233, 0, 0, 1'b0, 5, 1, 32'h00000000, 2'd1, 2'd0, 1'b1, 3'd0, 5'd4,  5'd1, 5'd2,  2'd0};
        vecs[11] = '{32'hFFF08093, 3, 0, 1'b0, 8, 1, 32'hFFFFFFFF, 2'd0, 2'd1, 1'b1, 3'd0, 5'd1,  5'd1, 5'd31, 2'd0};

        rst_n = 1'b0;
        RUN = 1'b0;
        instruction = '0;
        alu_zero = 1'b0;
        BUS_rdata_valid = 1'b0;
        BUS_write_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst_hold");
        chk("rst_hold.fields", 64'({reg_rd, reg_rs1, reg_rs2}), 64'd0);
        chk("rst_hold.im", 64'(IM), 64'd0);
        chk("rst_hold.bus_error", 64'(bus_error), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_idle");

        for (int i = 0; i < 12; i++) begin
            exec_instr(vecs[i].ins, vecs[i].fw, vecs[i].mw, vecs[i].z, o);
            chk($sformatf("v%0d.done", i),     64'(o.done),     64'd1);
            chk($sformatf("v%0d.cycles", i),   64'(o.cycles),   64'(vecs[i].cycles));
            chk($sformatf("v%0d.starts", i),   64'(o.starts),   64'(vecs[i].starts));
            chk($sformatf("v%0d.im", i),       64'(o.im),       64'(vecs[i].im));
            chk($sformatf("v%0d.alu_mode", i), 64'(o.mode),     64'(vecs[i].mode));
            chk($sformatf("v%0d.alu_cs1", i),  64'(o.cs1),      64'd0);
            chk($sformatf("v%0d.alu_cs2", i),  64'(o.cs2),      64'(vecs[i].cs2));
            chk($sformatf("v%0d.rs1", i),      64'(o.rs1),      64'(vecs[i].rs1));
            chk($sformatf("v%0d.rs2", i),      64'(o.rs2),      64'(vecs[i].rs2));
            chk($sformatf("v%0d.wen", i),      64'(o.wen),      64'(vecs[i].wen));
            chk($sformatf("v%0d.wen_cnt", i),  64'(o.wen_cnt),  64'(vecs[i].wen));
            chk($sformatf("v%0d.mux", i),      64'(o.mux),      64'(vecs[i].mux));
            chk($sformatf("v%0d.rd", i),       64'(o.rd),       64'(vecs[i].rd));
            chk($sformatf("v%0d.pc_cs", i),    64'(o.pccs),     64'(vecs[i].pccs));
            chk($sformatf("v%0d.pc_en", i),    64'(o.pcen),     64'd1);
            chk($sformatf("v%0d.pcen_cnt", i), 64'(o.pcen_cnt), 64'd1);
            chk($sformatf("v%0d.idle", i),     64'(cur_state),  64'(ST_IDLE));
        end

        // Response in the start cycle must be ignored; late responses ignored outside FETCH/MEM.
        instruction = 32'h00500093;
        RUN = 1'b1;
        @(negedge clk);
        chk("sv.start", 64'(BUS_start_transaction), 64'd1);
        BUS_rdata_valid = 1'b1;
        RUN = 1'b0;
        @(negedge clk);
        BUS_rdata_valid = 1'b0;
        chk("sv.still_fetch", 64'(cur_state), 64'(ST_FETCH));
        chk("sv.no_restart", 64'(BUS_start_transaction), 64'd0);
        @(negedge clk);
        chk("sv.still_fetch2", 64'(cur_state), 64'(ST_FETCH));
        BUS_rdata_valid = 1'b1;
        @(negedge clk);
        chk("sv.decode", 64'(cur_state), 64'(ST_DECODE));
        BUS_write_done = 1'b1;
        @(negedge clk);
        chk("sv.exec", 64'(cur_state), 64'(ST_EXEC));
        @(negedge clk);
        chk("sv.wb", 64'(cur_state), 64'(ST_WB));
        @(negedge clk);
        chk("sv.idle", 64'(cur_state), 64'(ST_IDLE));
        @(negedge clk);
        chk("sv.idle_hold", 64'(cur_state), 64'(ST_IDLE));
        chk("sv.idle_nostart", 64'(BUS_start_transaction), 64'd0);
        BUS_rdata_valid = 1'b0;
        BUS_write_done = 1'b0;
        @(negedge clk);

        // Illegal all-zero opcode: sticky trap, no more bus activity until reset.
        exec_instr(32'h00000000, 0, 0, 1'b0, o);
        chk("trap0.trapped", 64'(o.trapped), 64'd1);
        chk("trap0.starts", 64'(o.starts), 64'd1);
        chk("trap0.wen_cnt", 64'(o.wen_cnt), 64'd0);
        RUN = 1'b1;
        cnt_start = 0;
        cnt_en = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            BUS_rdata_valid = i[0];
            BUS_write_done = ~i[0];
            if (BUS_start_transaction) cnt_start++;
            if (reg_wen || PC_EN) cnt_en++;
        end
        chk("trap0.state", 64'(cur_state), 64'(ST_TRAP));
        chk("trap0.flag", 64'(trap), 64'd1);
        chk("trap0.no_start", 64'(cnt_start), 64'd0);
        chk("trap0.no_enable", 64'(cnt_en), 64'd0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("trap0.rst");
        do_reset();

        // ADD with a non-zero funct7 is not in the subset.
        exec_instr(32'h02208233, 0, 0, 1'b0, o);
        chk("trap1.trapped", 64'(o.trapped), 64'd1);
        chk("trap1.flag", 64'(trap), 64'd1);
        do_reset();

        // Async reset while MEM waits for the LW response.
        instruction = 32'h0080A283;
        RUN = 1'b1;
        @(negedge clk);
        RUN = 1'b0;
        @(negedge clk);
        BUS_rdata_valid = 1'b1;
        @(negedge clk);
        BUS_rdata_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr.mem", 64'(cur_state), 64'(ST_MEM));
        chk("mr.start", 64'({BUS_start_transaction, BUS_ADDR_CS, BUS_mode}), 64'b110);
        @(negedge clk);
        chk("mr.wait", 64'(cur_state), 64'(ST_MEM));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mr.async");
        chk("mr.im", 64'(IM), 64'd0);
        do_reset();
        chk_all_zero("mr.after");

`ifdef CU_BUS_TIMEOUT_EN
        instruction = 32'h00500093;
        RUN = 1'b1;
        @(negedge clk);
        chk("to.start", 64'(BUS_start_transaction), 64'd1);
        RUN = 1'b0;
        repeat (TO) @(negedge clk);
        chk("to.limit_fetch", 64'(cur_state), 64'(ST_FETCH));
        chk("to.limit_err", 64'(bus_error), 64'd0);
        @(negedge clk);
        chk("to.trap", 64'(cur_state), 64'(ST_TRAP));
        chk("to.bus_error", 64'(bus_error), 64'd1);
        chk("to.trap_flag", 64'(trap), 64'd1);
        do_reset();
        chk("to.err_clear", 64'(bus_error), 64'd0);
        RUN = 1'b1;
        @(negedge clk);
        RUN = 1'b0;
        repeat (TO) @(negedge clk);
        BUS_rdata_valid = 1'b1;
        @(negedge clk);
        BUS_rdata_valid = 1'b0;
        chk("to.edge_accept", 64'(cur_state), 64'(ST_DECODE));
        chk("to.edge_err", 64'(bus_error), 64'd0);
        repeat (4) @(negedge clk);
        chk("to.edge_idle", 64'(cur_state), 64'(ST_IDLE));
`else
        instruction = 32'h00500093;
        RUN = 1'b1;
        @(negedge clk);
        RUN = 1'b0;
        repeat (30) @(negedge clk);
        chk("nto.wait", 64'(cur_state), 64'(ST_FETCH));
        chk("nto.bus_error", 64'(bus_error), 64'd0);
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
